// File: rtl/sdram_arbit_pkg.sv
// Shared constants for the SDRAM arbiter: bus widths, SDRAM command encodings,
// arbiter state encoding and grant selection codes.
package sdram_arbit_pkg;

  localparam int ADDR_W = 12;
  localparam int BANK_W = 2;
  localparam int CMD_W  = 4;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_ACT       = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WR        = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_RD        = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF      = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MRS       = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_REF,
    GNT_WR,
    GNT_RD
  } gnt_e;

endpackage

// File: rtl/sdram_arbit_sel.sv
// Priority pick among pending stage requests (refresh > starved read > write > read)
// plus the read-starvation counter, which only moves while the arbiter is idle.
module sdram_arbit_sel
  import sdram_arbit_pkg::*;
#(
  parameter int RD_STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_arbit,
  input  logic ref_req,
  input  logic wr_req,
  input  logic rd_req,
  output gnt_e gnt
);

  localparam logic [3:0] STARVE_MAX = 4'(RD_STARVE_MAX);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  always_comb begin
    gnt = GNT_NONE;
    if (in_arbit) begin
      if (ref_req)                               gnt = GNT_REF;
      else if (rd_req && starve_cnt_q == STARVE_MAX) gnt = GNT_RD;
      else if (wr_req)                           gnt = GNT_WR;
      else if (rd_req)                           gnt = GNT_RD;
    end
  end

  // Refresh grants leave the count untouched; it tracks writes jumping a waiting read.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (in_arbit) begin
      if (!rd_req || gnt == GNT_RD)
        starve_cnt_d = 4'd0;
      else if (gnt == GNT_WR && starve_cnt_q != STARVE_MAX)
        starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= 4'd0;
    else     starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM controller arbiter: grants init/refresh/write/read stages one at a time with
// one-cycle enable pulses and muxes the granted stage's command/address/bank onto the pins.
module sdram_arbit
  import sdram_arbit_pkg::*;
#(
  parameter int RD_STARVE_MAX = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              ref_req,
  input  logic              ref_end,
  input  logic [CMD_W-1:0]  ref_cmd,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [CMD_W-1:0]  rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              ref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr
);

  arb_state_e state_q, state_d;
  logic ref_en_q, ref_en_d;
  logic wr_en_q, wr_en_d;
  logic rd_en_q, rd_en_d;
  gnt_e gnt;

  logic [CMD_W-1:0] bus_cmd;

  sdram_arbit_sel #(
    .RD_STARVE_MAX(RD_STARVE_MAX)
  ) u_sel (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .in_arbit(state_q == ST_ARBIT),
    .ref_req (ref_req),
    .wr_req  (wr_req),
    .rd_req  (rd_req),
    .gnt     (gnt)
  );

  // Busy states exit only through ARBIT, so a grant is exactly an ARBIT->stage transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  if (init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        unique case (gnt)
          GNT_REF:  state_d = ST_AREF;
          GNT_WR:   state_d = ST_WRITE;
          GNT_RD:   state_d = ST_READ;
          default:  state_d = ST_ARBIT;
        endcase
      end
      ST_AREF:  if (ref_end) state_d = ST_ARBIT;
      ST_WRITE: if (wr_end)  state_d = ST_ARBIT;
      ST_READ:  if (rd_end)  state_d = ST_ARBIT;
      default:  state_d = ST_INIT;
    endcase
    ref_en_d = (gnt == GNT_REF);
    wr_en_d  = (gnt == GNT_WR);
    rd_en_d  = (gnt == GNT_RD);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_INIT;
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_en_q <= ref_en_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
    end
  end

  always_comb begin
    bus_cmd    = CMD_NOP;
    sdram_addr = '0;
    sdram_ba   = '0;
    if (sys_rst || state_q == ST_INIT) begin
      bus_cmd    = init_cmd;
      sdram_addr = init_addr;
    end else begin
      unique case (state_q)
        ST_AREF: begin
          bus_cmd    = ref_cmd;
          sdram_addr = ref_addr;
        end
        ST_WRITE: begin
          bus_cmd    = wr_cmd;
          sdram_addr = wr_addr;
          sdram_ba   = wr_bank;
        end
        ST_READ: begin
          bus_cmd    = rd_cmd;
          sdram_addr = rd_addr;
          sdram_ba   = rd_bank;
        end
        default: ;
      endcase
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = bus_cmd;
  assign sdram_cke = 1'b1;
  assign ref_en    = ref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench: stimulus pushes expected grants to a queue, a negedge monitor pops and
// checks each enable pulse and the pins presented with it; direct bus checks run inline.
module tb_sdram_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic [3:0]  init_cmd  = 4'b0010;
  logic [11:0] init_addr = 12'h400;
  logic        ref_req, ref_end;
  logic [3:0]  ref_cmd   = 4'b0001;
  logic [11:0] ref_addr  = 12'h000;
  logic        wr_req, wr_end;
  logic [3:0]  wr_cmd    = 4'b0100;
  logic [11:0] wr_addr   = 12'h405;
  logic [1:0]  wr_bank   = 2'd2;
  logic        rd_req, rd_end;
  logic [3:0]  rd_cmd    = 4'b0101;
  logic [11:0] rd_addr   = 12'h123;
  logic [1:0]  rd_bank   = 2'd1;
  logic        ref_en, wr_en, rd_en;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  en;    // {ref, wr, rd}
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  ba;
  } exp_t;

  exp_t exp_q[$];

  sdram_arbit #(.RD_STARVE_MAX(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [3:0] cmd, input logic [11:0] addr,
                         input logic [1:0] ba);
    chk(name, {14'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
        {14'd0, cmd, ba, addr});
  endtask

  task automatic chk_en(input string name, input logic [2:0] exp);
    chk(name, {29'd0, ref_en, wr_en, rd_en}, {29'd0, exp});
  endtask

  task automatic push(input logic [2:0] en, input logic [3:0] cmd, input logic [11:0] addr,
                      input logic [1:0] ba);
    exp_t e;
    e.en = en; e.cmd = cmd; e.addr = addr; e.ba = ba;
    exp_q.push_back(e);
  endtask

  task automatic push_ref(); push(3'b100, 4'b0001, 12'h000, 2'd0); endtask
  task automatic push_wr();  push(3'b010, 4'b0100, 12'h405, 2'd2); endtask
  task automatic push_rd();  push(3'b001, 4'b0101, 12'h123, 2'd1); endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Monitor: every enable pulse must match the next queued grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if ((ref_en | wr_en | rd_en) === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got en=%b expected none", {ref_en, wr_en, rd_en});
        end else begin
          e = exp_q.pop_front();
          chk("grant_en", {29'd0, ref_en, wr_en, rd_en}, {29'd0, e.en});
          chk_bus("grant_bus", e.cmd, e.addr, e.ba);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1; init_end = 1'b0;
    ref_req = 0; ref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;

    // Reset and init phase
    tick();
    chk_bus("rst_bus", 4'b0010, 12'h400, 2'd0);
    chk_en("rst_en", 3'b000);
    chk("rst_cke", {31'd0, sdram_cke}, 32'd1);
    chk("rst_starve", {28'd0, dut.u_sel.starve_cnt_q}, 32'd0);
    tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_bus("init_bus", 4'b0010, 12'h400, 2'd0);
      chk_en("init_en", 3'b000);
    end
    init_end = 1'b1;
    tick();
    chk_bus("arbit_nop", 4'b0111, 12'h000, 2'd0);
    chk_en("arbit_en", 3'b000);
    tick();
    chk_bus("arbit_idle", 4'b0111, 12'h000, 2'd0);

    // All three requests: refresh, then write, then read
    ref_req = 1; wr_req = 1; rd_req = 1;
    push_ref();
    tick();
    chk_en("ref_first", 3'b100);
    tick();
    chk_en("ref_pulse_once", 3'b000);
    ref_req = 0; ref_end = 1;
    push_wr();
    tick();
    ref_end = 0;
    chk_bus("post_ref_nop", 4'b0111, 12'h000, 2'd0);
    chk_en("post_ref_en", 3'b000);
    tick();
    chk_en("wr_second", 3'b010);
    chk_bus("wr_bus", 4'b0100, 12'h405, 2'd2);
    rd_end = 1; ref_end = 1;
    tick();
    rd_end = 0; ref_end = 0;
    chk_bus("wr_spurious_end", 4'b0100, 12'h405, 2'd2);
    chk_en("wr_spurious_en", 3'b000);
    tick();
    chk_bus("wr_hold", 4'b0100, 12'h405, 2'd2);
    wr_end = 1; wr_req = 0;
    push_rd();
    tick();
    wr_end = 0;
    chk_bus("post_wr_nop", 4'b0111, 12'h000, 2'd0);
    chk_en("post_wr_en", 3'b000);
    tick();
    chk_en("rd_third", 3'b001);
    chk_bus("rd_bus", 4'b0101, 12'h123, 2'd1);
    rd_req = 0; rd_end = 1;
    tick();
    rd_end = 0;

    // Starvation guard; init_end dropping outside INIT must be ignored
    init_end = 0; rd_req = 1; wr_req = 1;
    for (int k = 0; k < 4; k++) push_wr();
    push_rd();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_en("starve_wr", 3'b010);
      wr_end = 1;
      tick();
      wr_end = 0;
      chk_bus("starve_nop", 4'b0111, 12'h000, 2'd0);
    end
    chk("starve_cnt_max", {28'd0, dut.u_sel.starve_cnt_q}, 32'd4);
    tick();
    chk_en("starve_rd", 3'b001);
    chk("starve_cnt_clr", {28'd0, dut.u_sel.starve_cnt_q}, 32'd0);

    // End pulse and new request in the same cycle: end wins, NOP cycle follows
    rd_req = 0; wr_req = 1; rd_end = 1;
    push_wr();
    tick();
    rd_end = 0;
    chk_bus("end_wins_nop", 4'b0111, 12'h000, 2'd0);
    chk_en("end_wins_en", 3'b000);
    tick();
    chk_en("end_wins_wr", 3'b010);
    wr_req = 0; wr_end = 1; rd_req = 1;
    push_rd();
    tick();
    wr_end = 0;
    tick();
    chk_en("pre_rst_rd", 3'b001);

    // Reset in the middle of a read
    tick();
    chk_bus("in_read", 4'b0101, 12'h123, 2'd1);
    sys_rst = 1;
    tick();
    sys_rst = 0; rd_req = 0;
    chk_bus("midrst_bus", 4'b0010, 12'h400, 2'd0);
    chk_en("midrst_en", 3'b000);
    tick();
    chk_bus("midrst_wait_init", 4'b0010, 12'h400, 2'd0);
    tick();
    chk_bus("midrst_wait_init2", 4'b0010, 12'h400, 2'd0);
    init_end = 1;
    tick();
    chk_bus("midrst_arbit", 4'b0111, 12'h000, 2'd0);
    chk_en("midrst_arbit_en", 3'b000);
    tick();
    tick();
    chk("grants_all_seen", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
